// File: rtl/beam_trigger_scaler.sv
// beam_trigger_scaler
//   Qualifies per-beam trigger bits with a programmable holdoff, produces a
//   registered OR'ed L1 trigger, counts qualified triggers per beam over a
//   programmable gate, and streams a per-gate snapshot of the counts out over
//   a valid/ready port.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   trig_i         per-beam raw trigger bits
//   holdoff_i      blind time (clocks) loaded after each qualified trigger
//   period_i       gate length in clocks minus 1
//   mask_i         1 = beam excluded from trig_o (still counted)
//   trig_o         registered OR of unmasked qualified triggers
//   beam_o         registered qualified per-beam pulses
//   rd_*           snapshot readout (valid/ready, beam index, count, last)
//   rd_dropped_o   1-clock pulse when a gate closes while readout is busy

// Per-beam lane: holdoff counter, saturating accumulator and snapshot shadow.
module beam_trigger_scaler_lane #(
  parameter int CNTBITS      = 16,
  parameter int HOLDOFF_BITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    trig_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    gate_end_i,
  input  logic                    capture_i,
  output logic                    qual_o,
  output logic [CNTBITS-1:0]      shadow_o
);
  logic [HOLDOFF_BITS-1:0] hold_cnt;
  logic [CNTBITS-1:0]      acc, acc_nxt;

  assign qual_o  = trig_i && (hold_cnt == '0);
  // Includes the current cycle's qualification so a trigger in the terminal
  // cycle lands in the closing gate's snapshot.
  assign acc_nxt = (acc == '1) ? acc : acc + CNTBITS'(qual_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_cnt <= '0;
      acc      <= '0;
      shadow_o <= '0;
    end else begin
      if (qual_o)               hold_cnt <= holdoff_i;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HOLDOFF_BITS'(1);
      acc <= gate_end_i ? '0 : acc_nxt;
      if (capture_i) shadow_o <= acc_nxt;
    end
  end
endmodule

module beam_trigger_scaler #(
  parameter  int NBEAMS       = 2,
  parameter  int CNTBITS      = 16,
  parameter  int HOLDOFF_BITS = 4,
  parameter  int PERIOD_BITS  = 24,
  localparam int IDXW         = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NBEAMS-1:0]       trig_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [PERIOD_BITS-1:0]  period_i,
  input  logic [NBEAMS-1:0]       mask_i,
  output logic                    trig_o,
  output logic [NBEAMS-1:0]       beam_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [IDXW-1:0]         rd_beam_o,
  output logic [CNTBITS-1:0]      rd_count_o,
  output logic                    rd_last_o,
  output logic                    rd_dropped_o
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t                           state, state_nxt;
  logic [NBEAMS-1:0]                qual;
  logic [NBEAMS-1:0][CNTBITS-1:0]   shadow;
  logic [PERIOD_BITS-1:0]           gate_cnt, period_reg, period_eff;
  logic                             started, gate_end, capture, last, accept;
  logic [IDXW-1:0]                  idx;

  for (genvar b = 0; b < NBEAMS; b++) begin : g_lane
    beam_trigger_scaler_lane #(
      .CNTBITS      (CNTBITS),
      .HOLDOFF_BITS (HOLDOFF_BITS)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .trig_i     (trig_i[b]),
      .holdoff_i  (holdoff_i),
      .gate_end_i (gate_end),
      .capture_i  (capture),
      .qual_o     (qual[b]),
      .shadow_o   (shadow[b])
    );
  end

  // The first gate after reset uses period_i directly; period_reg only
  // becomes authoritative once it has been loaded on that first clock.
  assign period_eff = started ? period_reg : period_i;
  assign gate_end   = (gate_cnt == period_eff);
  assign capture    = gate_end && (state == IDLE);
  assign last       = (idx == IDXW'(NBEAMS - 1));
  assign accept     = (state == SEND) && rd_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      started    <= 1'b0;
      period_reg <= '0;
      gate_cnt   <= '0;
    end else begin
      started <= 1'b1;
      if (gate_end || !started) period_reg <= period_i;
      gate_cnt <= gate_end ? '0 : gate_cnt + PERIOD_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_o       <= 1'b0;
      beam_o       <= '0;
      rd_dropped_o <= 1'b0;
      idx          <= '0;
    end else begin
      trig_o       <= |(qual & ~mask_i);
      beam_o       <= qual;
      rd_dropped_o <= gate_end && (state == SEND);
      if (capture || (accept && last)) idx <= '0;
      else if (accept)                 idx <= idx + IDXW'(1);
    end
  end

  // Readout FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gate_end)      state_nxt = SEND;
      SEND:    if (accept && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_valid_o = 1'b0;
    rd_beam_o  = '0;
    rd_count_o = '0;
    rd_last_o  = 1'b0;
    if (state == SEND) begin
      rd_valid_o = 1'b1;
      rd_beam_o  = idx;
      rd_count_o = shadow[idx];
      rd_last_o  = last;
    end
  end
endmodule
